mdio_master_ctrl: RTL and testbench
===================================

# mdio_master_ctrl

Parametrised MDIO management master that generates MDC internally and runs complete Clause 22 and Clause 45 management frames. Frame options are a configurable preamble length, turnaround-error detection, and rejection of illegal command encodings. It sits between the PHY-init sequencer and the external PHY management pins, and accepts one operation at a time over a valid/ready handshake.

## Interface

**Parameters**
- `P_CLK_DIV`, default 4: `i_mdio_clk` cycles per MDC half-period. Legal range 1..255.
- `P_PREAMBLE_LEN`, default 32: number of preamble '1' bits. Legal range 0..32. A value of 0 gives preamble suppression.
- `P_C45_EN`, default 1: 0 removes Clause 45 support. With 0, any op with `i_clause45`=1 is rejected.

**Ports**
- `i_mdio_clk` in 1: the block's single clock.
- `i_mdio_rst` in 1: reset, asynchronous and active-high.
- `o_mdc` in→out 1: management clock to the PHY. Low when idle.
- `io_mdio` inout 1: management data. High-Z when not driven.
- `i_op_valid` in 1: operation request.
- `o_op_ready` out 1: block idle and able to accept an operation.
- `i_clause45` in 1: selects frame type. 0 = Clause 22 (ST=01), 1 = Clause 45 (ST=00).
- `i_op_cmd` in 2: the OP field.
  - Clause 22: 01 = write, 10 = read.
  - Clause 45: 00 = address, 01 = write, 11 = read, 10 = read-increment.
- `i_phy_addr` in 5: PHYAD (PRTAD for Clause 45).
- `i_reg_addr` in 5: REGAD (DEVAD for Clause 45).
- `i_reg_data` in 16: write data, or the address for a Clause 45 address op.
- `o_read_data` out 16: last read result. Holds its value until the next read completes.
- `o_read_valid` out 1: one-cycle pulse when read data is updated.
- `o_ta_err` out 1: one-cycle pulse, coincident with `o_read_valid`, when the PHY did not drive TA bit 2 low.
- `o_cmd_err` out 1: one-cycle pulse when an illegal op is rejected.

## Operation

**Handshake**
- An op is accepted when `i_op_valid` & `o_op_ready` are both high. All inputs are registered in the accept cycle.
- Illegal ops are rejected: Clause 22 with OP 00 or 11, or `i_clause45`=1 with `P_C45_EN`=0.
  - A rejected op pulses `o_cmd_err` on the next cycle.
  - No frame is sent and `o_op_ready` stays high.

**State machine**
- IDLE → PRE → HDR → TA → DATA → END → IDLE.
- PRE is skipped when `P_PREAMBLE_LEN`=0.
- Bit counts per state:
  - PRE: `P_PREAMBLE_LEN` bits of '1'.
  - HDR: 14 bits, sent MSB first: ST[1:0], OP[1:0], PHYAD[4:0], REGAD[4:0].
  - TA: 2 bits.
  - DATA: 16 bits, MSB first.
  - END: 1 bit with MDIO released.

**Read types** (Clause 22 OP=10, or Clause 45 OP=11 or 10)
- MDIO is driven through the end of HDR.
- MDIO is released for TA and DATA.
- TA bit 2 is sampled and must be 0.
- Each DATA bit is shifted in MSB first.

**Write types** (Clause 22 OP=01, or Clause 45 OP=01 or 00)
- MDIO is driven through PRE, HDR, TA (10) and DATA.
- MDIO is released in END.

**Bit timing**
- Bit period = 2·`P_CLK_DIV` clocks.
- `o_mdc` is low for the first half and high for the second half of each bit.
- The MDIO output changes only at the start of a bit (MDC falling edge or start of frame).
- Input is sampled in the clock cycle in which `o_mdc` goes high.
- The MDC divider counter and the bit counter both reset at accept. MDC is therefore phase-aligned to every frame.

## Timing

**Reset values**
- `o_mdc`=0 and `io_mdio`=Z.
- `o_op_ready`=1.
- `o_read_data`=0.
- `o_read_valid`, `o_ta_err` and `o_cmd_err` are all 0.

**Frame length**
- N = `P_PREAMBLE_LEN` + 33 bits.

**Cycle-level timing** (accept at cycle T)
- `o_op_ready` is 0 from T+1.
- The first bit starts at T+1.
- `o_read_valid` (reads only) and `o_ta_err` pulse at T+1+N·2·`P_CLK_DIV`.
- `o_op_ready` returns to 1 in that same cycle. The earliest next accept is that cycle.
- With default parameters, `o_op_ready` is low for 65·8 = 520 cycles.

**Error and reset behaviour**
- A TA error does not abort the frame. Data is still captured and `o_read_valid` still pulses.
- Reset asserted mid-frame: all outputs take their reset values asynchronously, `io_mdio` goes Z immediately, and the frame is abandoned.
- `i_op_valid` is ignored while `o_op_ready`=0. Inputs may change freely outside the accept cycle.

## Test plan

1. **Clause 22 write, defaults.** PHY 5'h01, REG 5'h00, data 16'h1140.
   - MDIO carries 32×'1', then 01 01 00001 00000 10 0001000101000000.
   - Nothing is sampled.
   - `o_op_ready` is low for 520 cycles.
2. **Clause 22 read.** PHY 5'h01, REG 5'h02. PHY model drives TA=Z0 and data 16'h004D.
   - `o_read_data`=16'h004D.
   - `o_read_valid` pulses once, 520 cycles after accept.
   - `o_ta_err`=0.
   - The master releases MDIO from the TA start.
3. **Clause 45 sequence.** Address op (DEVAD 5'h07, addr 16'h0020), then read op (OP=11). PHY returns 16'hABCD.
   - ST=00 on both frames.
   - `o_read_data`=16'hABCD.
   - Back-to-back accept is honoured on the cycle ready returns.
4. **TA error.** PHY model leaves MDIO pulled high during a read.
   - `o_ta_err` and `o_read_valid` pulse together.
   - `o_read_data`=16'hFFFF.
5. **Illegal command.** `i_clause45`=0 with `i_op_cmd`=2'b11.
   - `o_cmd_err` pulses at T+1.
   - `o_mdc` stays 0 and MDIO stays Z.
   - `o_op_ready` stays 1.
6. **Parameters and mid-frame reset.** `P_PREAMBLE_LEN`=0, `P_CLK_DIV`=1, with reset asserted during DATA.
   - The frame starts directly with ST.
   - The MDC period is 2 clocks.
   - On reset, `io_mdio` goes Z, `o_mdc`=0 and `o_op_ready`=1 immediately.

Source files
------------

// File: rtl/mdio_master_ctrl.sv
// MDIO management master: generates MDC and runs one Clause 22 / Clause 45
// frame per accepted op, capturing read data and turnaround errors.
module mdio_master_ctrl #(
    parameter int P_CLK_DIV      = 4,
    parameter int P_PREAMBLE_LEN = 32,
    parameter int P_C45_EN       = 1
) (
    input  logic        i_mdio_clk,
    input  logic        i_mdio_rst,
    output logic        o_mdc,
    inout  wire         io_mdio,
    input  logic        i_op_valid,
    output logic        o_op_ready,
    input  logic        i_clause45,
    input  logic [1:0]  i_op_cmd,
    input  logic [4:0]  i_phy_addr,
    input  logic [4:0]  i_reg_addr,
    input  logic [15:0] i_reg_data,
    output logic [15:0] o_read_data,
    output logic        o_read_valid,
    output logic        o_ta_err,
    output logic        o_cmd_err
);
    localparam int DIV_W = 8;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(P_CLK_DIV - 1);
    localparam logic [5:0] PRE_LAST = (P_PREAMBLE_LEN > 0) ? 6'(P_PREAMBLE_LEN - 1) : 6'd0;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_END} state_t;
    state_t state, state_nxt;

    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       bit_cnt;
    logic [31:0]      tx_sr;
    logic [15:0]      rx_sr;
    logic             is_read;
    logic             ta_bad;
    logic             mdc;

    logic op_c22_ok, op_ok, op_is_read;
    logic accept, start, reject;
    logic half_end, mdc_rise, bit_end, state_done;
    logic mdio_in, mdio_oe, mdio_bit;

    assign op_c22_ok  = (i_op_cmd == 2'b01) || (i_op_cmd == 2'b10);
    assign op_ok      = i_clause45 ? (P_C45_EN != 0) : op_c22_ok;
    assign op_is_read = i_clause45 ? i_op_cmd[1] : (i_op_cmd == 2'b10);

    assign accept = i_op_valid && (state == S_IDLE);
    assign start  = accept && op_ok;
    assign reject = accept && !op_ok;

    // One bit = two half periods of P_CLK_DIV clocks; mdc low then high.
    assign half_end = (state != S_IDLE) && (div_cnt == DIV_LAST);
    assign mdc_rise = half_end && !mdc;
    assign bit_end  = half_end && mdc;

    always_ff @(posedge i_mdio_clk or posedge i_mdio_rst) begin
        if (i_mdio_rst) state <= S_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        state_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = (P_PREAMBLE_LEN > 0) ? S_PRE : S_HDR;
            end
            S_PRE: begin
                state_done = (bit_cnt == PRE_LAST);
                if (bit_end && state_done) state_nxt = S_HDR;
            end
            S_HDR: begin
                state_done = (bit_cnt == 6'd13);
                if (bit_end && state_done) state_nxt = S_TA;
            end
            S_TA: begin
                state_done = (bit_cnt == 6'd1);
                if (bit_end && state_done) state_nxt = S_DATA;
            end
            S_DATA: begin
                state_done = (bit_cnt == 6'd15);
                if (bit_end && state_done) state_nxt = S_END;
            end
            S_END: begin
                state_done = 1'b1;
                if (bit_end) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_mdio_clk or posedge i_mdio_rst) begin
        if (i_mdio_rst) begin
            div_cnt      <= '0;
            bit_cnt      <= '0;
            mdc          <= 1'b0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            is_read      <= 1'b0;
            ta_bad       <= 1'b0;
            o_read_data  <= '0;
            o_read_valid <= 1'b0;
            o_ta_err     <= 1'b0;
            o_cmd_err    <= 1'b0;
        end else begin
            o_read_valid <= 1'b0;
            o_ta_err     <= 1'b0;
            o_cmd_err    <= reject;
            if (start) begin
                div_cnt <= '0;
                bit_cnt <= '0;
                mdc     <= 1'b0;
                // Everything after the preamble, MSB first; TA/DATA only go out on writes.
                tx_sr   <= {(i_clause45 ? 2'b00 : 2'b01), i_op_cmd, i_phy_addr,
                            i_reg_addr, 2'b10, i_reg_data};
                is_read <= op_is_read;
                ta_bad  <= 1'b0;
            end else if (state != S_IDLE) begin
                if (half_end) begin
                    div_cnt <= '0;
                    mdc     <= ~mdc;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
                if (mdc_rise) begin
                    if (state == S_TA && bit_cnt == 6'd1) ta_bad <= mdio_in;
                    if (state == S_DATA) rx_sr <= {rx_sr[14:0], mdio_in};
                end
                if (bit_end) begin
                    bit_cnt <= state_done ? 6'd0 : bit_cnt + 6'd1;
                    if (state == S_HDR || state == S_TA || state == S_DATA)
                        tx_sr <= {tx_sr[30:0], 1'b0};
                    if (state == S_END && is_read) begin
                        o_read_data  <= rx_sr;
                        o_read_valid <= 1'b1;
                        o_ta_err     <= ta_bad;
                    end
                end
            end
        end
    end

    // Drive only from registered state so MDIO moves only at bit starts.
    assign mdio_bit = (state == S_PRE) ? 1'b1 : tx_sr[31];

    always_comb begin
        mdio_oe = 1'b0;
        case (state)
            S_PRE, S_HDR:  mdio_oe = 1'b1;
            S_TA, S_DATA:  mdio_oe = !is_read;
            default:       mdio_oe = 1'b0;
        endcase
    end

    assign io_mdio    = mdio_oe ? mdio_bit : 1'bz;
    assign mdio_in    = io_mdio;
    assign o_mdc      = mdc;
    assign o_op_ready = (state == S_IDLE);

endmodule

// File: tb/tb_mdio_master_ctrl.sv
// Bench for mdio_master_ctrl: default instance with a PHY model on a pulled-up
// line, plus a no-preamble / fast-MDC / no-Clause-45 instance.
module tb_mdio_master_ctrl;
    localparam int DIV_A = 4;
    localparam int PRE_A = 32;
    localparam int CYC_A = (PRE_A + 33) * 2 * DIV_A;
    localparam int DIV_B = 1;
    localparam int PRE_B = 0;
    localparam int CYC_B = (PRE_B + 33) * 2 * DIV_B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    wire  mdio_a, mdio_b;
    pullup pu_a (mdio_a);
    pullup pu_b (mdio_b);

    logic phy_oe = 1'b0, phy_out = 1'b0;
    assign mdio_a = phy_oe ? phy_out : 1'bz;

    logic        valid_a, ready_a, c45_a, mdc_a, rv_a, ta_a, ce_a;
    logic [1:0]  cmd_a;
    logic [4:0]  pa_a, ra_a;
    logic [15:0] d_a, rdata_a;
    logic        valid_b, ready_b, c45_b, mdc_b, rv_b, ta_b, ce_b;
    logic [1:0]  cmd_b;
    logic [4:0]  pa_b, ra_b;
    logic [15:0] d_b, rdata_b;

    mdio_master_ctrl #(.P_CLK_DIV(DIV_A), .P_PREAMBLE_LEN(PRE_A), .P_C45_EN(1)) dut_a (
        .i_mdio_clk(clk), .i_mdio_rst(rst_a), .o_mdc(mdc_a), .io_mdio(mdio_a),
        .i_op_valid(valid_a), .o_op_ready(ready_a), .i_clause45(c45_a), .i_op_cmd(cmd_a),
        .i_phy_addr(pa_a), .i_reg_addr(ra_a), .i_reg_data(d_a), .o_read_data(rdata_a),
        .o_read_valid(rv_a), .o_ta_err(ta_a), .o_cmd_err(ce_a));

    mdio_master_ctrl #(.P_CLK_DIV(DIV_B), .P_PREAMBLE_LEN(PRE_B), .P_C45_EN(0)) dut_b (
        .i_mdio_clk(clk), .i_mdio_rst(rst_b), .o_mdc(mdc_b), .io_mdio(mdio_b),
        .i_op_valid(valid_b), .o_op_ready(ready_b), .i_clause45(c45_b), .i_op_cmd(cmd_b),
        .i_phy_addr(pa_b), .i_reg_addr(ra_b), .i_reg_data(d_b), .o_read_data(rdata_b),
        .o_read_valid(rv_b), .o_ta_err(ta_b), .o_cmd_err(ce_b));

    int checks = 0;
    int passes = 0;

    // Line value seen at every MDC rising edge, per instance.
    logic line_a[$];
    logic line_b[$];
    logic mdc_prev_a = 1'b0, mdc_prev_b = 1'b0;

    logic [15:0] phy_data  = '0;
    logic        phy_read  = 1'b0;
    logic        phy_drive = 1'b0;

    // PHY: after each MDC fall, the number of completed bits names the next bit.
    always @(negedge clk) begin
        if (mdc_a && !mdc_prev_a) line_a.push_back(mdio_a);
        if (!mdc_a && mdc_prev_a) begin
            phy_oe <= phy_read && phy_drive && (line_a.size() >= PRE_A + 15) &&
                      (line_a.size() <= PRE_A + 31);
            if (line_a.size() == PRE_A + 15) phy_out <= 1'b0;
            else phy_out <= phy_data[4'(PRE_A + 31 - line_a.size())];
        end
        mdc_prev_a <= mdc_a;
    end

    always @(negedge clk) begin
        if (mdc_b && !mdc_prev_b) line_b.push_back(mdio_b);
        mdc_prev_b <= mdc_b;
    end

    // ---------------- reference model ----------------
    logic        exp_q[$];
    logic [15:0] exp_rd = '0;

    function automatic bit is_rd(input logic c45, input logic [1:0] op);
        return c45 ? (op == 2'b10 || op == 2'b11) : (op == 2'b10);
    endfunction

    function automatic bit is_legal(input logic c45, input logic [1:0] op, input bit c45_en);
        return c45 ? c45_en : (op == 2'b01 || op == 2'b10);
    endfunction

    // Expected line at each MDC rise; released bits read as the pull-up '1'.
    task automatic build_frame(input int pre, input logic c45, input logic [1:0] op,
                               input logic [4:0] pa, input logic [4:0] ra,
                               input logic [15:0] d, input bit ta_ok);
        logic [13:0] hdr;
        logic [15:0] body;
        exp_q.delete();
        repeat (pre) exp_q.push_back(1'b1);
        hdr = {(c45 ? 2'b00 : 2'b01), op, pa, ra};
        for (int i = 13; i >= 0; i--) exp_q.push_back(hdr[i]);
        exp_q.push_back(1'b1);
        if (is_rd(c45, op)) begin
            exp_q.push_back(!ta_ok);
            body = ta_ok ? d : 16'hFFFF;
        end else begin
            exp_q.push_back(1'b0);
            body = d;
        end
        for (int i = 15; i >= 0; i--) exp_q.push_back(body[i]);
        exp_q.push_back(1'b1);
    endtask

    function automatic int first_diff(input logic a[$], input logic b[$]);
        int n;
        n = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
        if (a.size() != b.size()) return n;
        return -1;
    endfunction

    // ---------------- stimulus for instance A ----------------
    int r_busy, r_rv_cnt, r_rv_idx, r_ta_cnt, r_ta_idx, r_ce_idx;

    task automatic do_op_a(input string name, input logic c45, input logic [1:0] op,
                           input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] d,
                           input bit ta_ok, input bit no_wait);
        int idx;
        if (!no_wait) @(negedge clk);
        line_a.delete();
        phy_read = is_rd(c45, op); phy_drive = ta_ok; phy_data = d;
        c45_a = c45; cmd_a = op; pa_a = pa; ra_a = ra; d_a = d; valid_a = 1'b1;
        @(posedge clk);
        r_busy = 0; r_rv_cnt = 0; r_rv_idx = -1; r_ta_cnt = 0; r_ta_idx = -1; r_ce_idx = -1;
        @(negedge clk);
        valid_a = 1'b0;
        c45_a = 1'($urandom); cmd_a = 2'($urandom); pa_a = 5'($urandom);
        ra_a = 5'($urandom); d_a = 16'($urandom);
        idx = 1;
        while (1'b1) begin
            if (rv_a) begin r_rv_cnt++; r_rv_idx = idx; end
            if (ta_a) begin r_ta_cnt++; r_ta_idx = idx; end
            if (ce_a) r_ce_idx = idx;
            if (ready_a || idx > CYC_A + 50) break;
            r_busy++;
            idx++;
            @(negedge clk);
        end
        checks++;
        if (ready_a !== 1'b1) $display("FAIL %s_done: ready still %b after %0d cycles, want 1", name, ready_a, idx);
        else passes++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ready_a !== 1'b1) $display("FAIL rst_ready: got %b want 1", ready_a); else passes++;
        checks++; if (mdc_a !== 1'b0) $display("FAIL rst_mdc: got %b want 0", mdc_a); else passes++;
        checks++; if (mdio_a !== 1'b1) $display("FAIL rst_mdio_released: line %b want pulled-up 1", mdio_a); else passes++;
        checks++; if (rdata_a !== 16'h0) $display("FAIL rst_rdata: got %h want 0000", rdata_a); else passes++;
        checks++; if ({rv_a, ta_a, ce_a} !== 3'b000) $display("FAIL rst_pulses: got %b want 000", {rv_a, ta_a, ce_a}); else passes++;
        checks++; if ({ready_b, mdc_b, rv_b, ta_b, ce_b} !== 5'b10000 || rdata_b !== 16'h0)
            $display("FAIL rst_b: got rdy/mdc/rv/ta/ce %b rdata %h want 10000 0000", {ready_b, mdc_b, rv_b, ta_b, ce_b}, rdata_b);
        else passes++;
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (ready_a !== 1'b1 || mdc_a !== 1'b0) $display("FAIL post_rst_idle: ready %b mdc %b want 1 0", ready_a, mdc_a); else passes++;
    endtask

    task automatic test_c22_write();
        int fd;
        do_op_a("c22w", 1'b0, 2'b01, 5'h01, 5'h00, 16'h1140, 1'b1, 1'b0);
        build_frame(PRE_A, 1'b0, 2'b01, 5'h01, 5'h00, 16'h1140, 1'b1);
        fd = first_diff(line_a, exp_q);
        checks++; if (fd != -1) $display("FAIL c22w_frame: first bad bit %0d (got %0d bits want %0d)", fd, line_a.size(), exp_q.size()); else passes++;
        checks++; if (r_busy != CYC_A) $display("FAIL c22w_busy: ready low %0d cycles want %0d", r_busy, CYC_A); else passes++;
        checks++; if (r_rv_cnt != 0 || rdata_a !== exp_rd) $display("FAIL c22w_no_read: rv pulses %0d rdata %h want 0 %h", r_rv_cnt, rdata_a, exp_rd); else passes++;
        checks++; if (r_ce_idx != -1) $display("FAIL c22w_cmd_err: pulsed at %0d want none", r_ce_idx); else passes++;
    endtask

    task automatic test_c22_read();
        int fd;
        do_op_a("c22r", 1'b0, 2'b10, 5'h01, 5'h02, 16'h004D, 1'b1, 1'b0);
        build_frame(PRE_A, 1'b0, 2'b10, 5'h01, 5'h02, 16'h004D, 1'b1);
        exp_rd = 16'h004D;
        fd = first_diff(line_a, exp_q);
        checks++; if (fd != -1) $display("FAIL c22r_frame: first bad bit %0d", fd); else passes++;
        checks++; if (rdata_a !== exp_rd) $display("FAIL c22r_data: got %h want %h", rdata_a, exp_rd); else passes++;
        checks++; if (r_rv_cnt != 1 || r_rv_idx != CYC_A + 1) $display("FAIL c22r_rv: %0d pulses at %0d want 1 at %0d", r_rv_cnt, r_rv_idx, CYC_A + 1); else passes++;
        checks++; if (r_ta_cnt != 0) $display("FAIL c22r_ta_err: %0d pulses want 0", r_ta_cnt); else passes++;
        checks++; if (line_a.size() > PRE_A + 14 && line_a[PRE_A + 14] !== 1'b1) $display("FAIL c22r_ta_release: TA bit1 line %b want 1", line_a[PRE_A + 14]);
        else if (line_a.size() <= PRE_A + 14) $display("FAIL c22r_ta_release: only %0d bits seen", line_a.size()); else passes++;
    endtask

    task automatic test_c45_seq();
        int fd;
        logic [4:0] pa;
        pa = 5'($urandom);
        do_op_a("c45a", 1'b1, 2'b00, pa, 5'h07, 16'h0020, 1'b1, 1'b0);
        build_frame(PRE_A, 1'b1, 2'b00, pa, 5'h07, 16'h0020, 1'b1);
        fd = first_diff(line_a, exp_q);
        checks++; if (fd != -1) $display("FAIL c45a_frame: first bad bit %0d", fd); else passes++;
        do_op_a("c45r", 1'b1, 2'b11, pa, 5'h07, 16'hABCD, 1'b1, 1'b1);
        build_frame(PRE_A, 1'b1, 2'b11, pa, 5'h07, 16'hABCD, 1'b1);
        exp_rd = 16'hABCD;
        fd = first_diff(line_a, exp_q);
        checks++; if (r_busy != CYC_A) $display("FAIL c45r_b2b_accept: busy %0d want %0d", r_busy, CYC_A); else passes++;
        checks++; if (fd != -1) $display("FAIL c45r_frame: first bad bit %0d", fd); else passes++;
        checks++; if (rdata_a !== exp_rd || r_rv_idx != CYC_A + 1) $display("FAIL c45r_data: got %h at %0d want %h at %0d", rdata_a, r_rv_idx, exp_rd, CYC_A + 1); else passes++;
    endtask

    task automatic test_ta_err();
        int fd;
        logic [4:0] pa, ra;
        pa = 5'($urandom); ra = 5'($urandom);
        do_op_a("taerr", 1'b0, 2'b10, pa, ra, 16'($urandom), 1'b0, 1'b0);
        build_frame(PRE_A, 1'b0, 2'b10, pa, ra, 16'h0000, 1'b0);
        exp_rd = 16'hFFFF;
        fd = first_diff(line_a, exp_q);
        checks++; if (fd != -1) $display("FAIL taerr_frame: first bad bit %0d", fd); else passes++;
        checks++; if (r_ta_cnt != 1 || r_rv_cnt != 1 || r_ta_idx != r_rv_idx)
            $display("FAIL taerr_pulse: ta %0d@%0d rv %0d@%0d want one each together", r_ta_cnt, r_ta_idx, r_rv_cnt, r_rv_idx);
        else passes++;
        checks++; if (rdata_a !== exp_rd) $display("FAIL taerr_data: got %h want %h", rdata_a, exp_rd); else passes++;
    endtask

    task automatic test_illegal();
        int nbad;
        do_op_a("illegal", 1'b0, 2'b11, 5'h03, 5'h04, 16'h1234, 1'b1, 1'b0);
        checks++; if (r_ce_idx != 1 || r_busy != 0) $display("FAIL illegal_cmd_err: at %0d busy %0d want at 1 busy 0", r_ce_idx, r_busy); else passes++;
        nbad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mdc_a !== 1'b0 || mdio_a !== 1'b1 || ready_a !== 1'b1 || ce_a !== 1'b0) nbad++;
        end
        checks++; if (nbad != 0 || line_a.size() != 0) $display("FAIL illegal_quiet: %0d bad cycles, %0d bits want 0 0", nbad, line_a.size()); else passes++;
    endtask

    task automatic test_random();
        int fd;
        logic c45; logic [1:0] op; logic [4:0] pa, ra; logic [15:0] d; bit ta_ok;
        for (int n = 0; n < 8; n++) begin
            c45 = 1'($urandom); op = 2'($urandom); pa = 5'($urandom); ra = 5'($urandom);
            d = 16'($urandom); ta_ok = ($urandom_range(0, 3) != 0);
            do_op_a("rand", c45, op, pa, ra, d, ta_ok, 1'($urandom));
            if (!is_legal(c45, op, 1'b1)) begin
                checks++; if (r_ce_idx != 1 || r_busy != 0 || line_a.size() != 0)
                    $display("FAIL rand%0d_reject: ce@%0d busy %0d bits %0d", n, r_ce_idx, r_busy, line_a.size());
                else passes++;
            end else begin
                build_frame(PRE_A, c45, op, pa, ra, d, ta_ok);
                fd = first_diff(line_a, exp_q);
                checks++; if (fd != -1 || r_busy != CYC_A) $display("FAIL rand%0d_frame: bad bit %0d busy %0d", n, fd, r_busy); else passes++;
                if (is_rd(c45, op)) begin
                    exp_rd = ta_ok ? d : 16'hFFFF;
                    checks++; if (r_rv_cnt != 1 || r_rv_idx != CYC_A + 1 || r_ta_cnt != int'(!ta_ok))
                        $display("FAIL rand%0d_read: rv %0d@%0d ta %0d want 1@%0d ta %0d", n, r_rv_cnt, r_rv_idx, r_ta_cnt, CYC_A + 1, int'(!ta_ok));
                    else passes++;
                end else begin
                    checks++; if (r_rv_cnt != 0 || r_ta_cnt != 0) $display("FAIL rand%0d_write: rv %0d ta %0d want 0 0", n, r_rv_cnt, r_ta_cnt); else passes++;
                end
                checks++; if (rdata_a !== exp_rd) $display("FAIL rand%0d_rdata: got %h want %h", n, rdata_a, exp_rd); else passes++;
            end
        end
    endtask

    task automatic test_params();
        int idx, nbad, fd;
        logic [4:0] pa, ra; logic [15:0] d;
        // Clause 45 compiled out: rejected.
        @(negedge clk);
        c45_b = 1'b1; cmd_b = 2'b11; valid_b = 1'b1;
        @(posedge clk); @(negedge clk);
        valid_b = 1'b0;
        checks++; if (ce_b !== 1'b1 || ready_b !== 1'b1 || mdc_b !== 1'b0)
            $display("FAIL b_c45_reject: ce %b ready %b mdc %b want 1 1 0", ce_b, ready_b, mdc_b);
        else passes++;
        // Write with no preamble and a 2-clock MDC.
        pa = 5'($urandom); ra = 5'($urandom); d = 16'($urandom);
        @(negedge clk);
        line_b.delete();
        c45_b = 1'b0; cmd_b = 2'b01; pa_b = pa; ra_b = ra; d_b = d; valid_b = 1'b1;
        @(posedge clk); @(negedge clk);
        valid_b = 1'b0;
        idx = 1; nbad = 0;
        while (!ready_b && idx <= CYC_B + 20) begin
            if (mdc_b !== ((idx % 2) == 0)) nbad++;
            idx++;
            @(negedge clk);
        end
        build_frame(PRE_B, 1'b0, 2'b01, pa, ra, d, 1'b1);
        fd = first_diff(line_b, exp_q);
        checks++; if (idx - 1 != CYC_B) $display("FAIL b_busy: %0d cycles want %0d", idx - 1, CYC_B); else passes++;
        checks++; if (nbad != 0) $display("FAIL b_mdc_period: %0d cycles off the 2-clock pattern, want 0", nbad); else passes++;
        checks++; if (fd != -1) $display("FAIL b_frame: first bad bit %0d", fd); else passes++;
        // Reset in the middle of DATA (bit 21, MDC high), data bit there is 0.
        d = 16'($urandom) & 16'hFBFF;
        @(negedge clk);
        c45_b = 1'b0; cmd_b = 2'b01; d_b = d; valid_b = 1'b1;
        @(posedge clk); @(negedge clk);
        valid_b = 1'b0;
        repeat (43) @(negedge clk);
        checks++; if (mdc_b !== 1'b1 || mdio_b !== 1'b0 || ready_b !== 1'b0)
            $display("FAIL b_mid_data: mdc %b mdio %b ready %b want 1 0 0", mdc_b, mdio_b, ready_b);
        else passes++;
        rst_b = 1'b1;
        #1;
        checks++; if (mdc_b !== 1'b0 || mdio_b !== 1'b1 || ready_b !== 1'b1)
            $display("FAIL b_async_rst: mdc %b mdio %b ready %b want 0 1 1", mdc_b, mdio_b, ready_b);
        else passes++;
        @(negedge clk);
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ready_b !== 1'b1 || mdc_b !== 1'b0 || rv_b !== 1'b0)
            $display("FAIL b_after_rst: ready %b mdc %b rv %b want 1 0 0", ready_b, mdc_b, rv_b);
        else passes++;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        valid_a = 1'b0; c45_a = 1'b0; cmd_a = 2'b00; pa_a = '0; ra_a = '0; d_a = '0;
        valid_b = 1'b0; c45_b = 1'b0; cmd_b = 2'b00; pa_b = '0; ra_b = '0; d_b = '0;
        test_reset();
        test_c22_write();
        test_c22_read();
        test_c45_seq();
        test_ta_err();
        test_illegal();
        test_random();
        test_params();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
